riscv_seq_multiplier_param: RTL and testbench

Parametrised iterative integer multiplier for the EX stage of the RISC-V core. It retires RADIX_BITS multiplier bits per cycle.
- Handles unsigned×unsigned, signed×signed and signed×unsigned operand combinations.
- Returns the full 2*XLEN-bit product and stalls the pipeline while a product is pending.
- Adds zero-operand early-out and a pipeline kill (flush) input.

---
 rtl/riscv_seq_multiplier_param_if.sv | 26 ++
 rtl/riscv_seq_multiplier_param.sv | 114 +++++++++++
 tb/tb_riscv_seq_multiplier_param.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_seq_multiplier_param_if.sv
// EX-stage request/response bundle between the pipeline and the iterative multiplier.
// The pipeline drives the master side; the multiplier uses the slave side.
interface riscv_seq_multiplier_param_if #(
  parameter int unsigned XLEN = 32
) ();
  logic              start_i;
  logic              kill_i;
  logic              id_a_signed_r;
  logic              id_b_signed_r;
  logic [XLEN-1:0]   id_ra_value_r;
  logic [XLEN-1:0]   id_rb_value_r;
  logic [2*XLEN-1:0] mul_res_r;
  logic              mul_valid_o;
  logic              busy_o;
  logic              ex_stall_mul_w;

  modport master (
    output start_i, kill_i, id_a_signed_r, id_b_signed_r, id_ra_value_r, id_rb_value_r,
    input  mul_res_r, mul_valid_o, busy_o, ex_stall_mul_w
  );

  modport slave (
    input  start_i, kill_i, id_a_signed_r, id_b_signed_r, id_ra_value_r, id_rb_value_r,
    output mul_res_r, mul_valid_o, busy_o, ex_stall_mul_w
  );
endinterface

// File: rtl/riscv_seq_multiplier_param.sv
// Iterative sign-magnitude multiplier retiring RADIX_BITS multiplier bits per cycle.
// Full 2*XLEN-bit product, optional zero-operand early-out, flush via kill_i.
module riscv_seq_multiplier_param #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RADIX_BITS = 2,
  parameter int unsigned EARLY_OUT  = 1
) (
  input logic                         clk_i,
  input logic                         rst_i,
  riscv_seq_multiplier_param_if.slave mul
);
  localparam int unsigned N    = XLEN / RADIX_BITS;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned AccW = XLEN + RADIX_BITS;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e              state_q, state_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;
  logic [XLEN-1:0]     mag_a_q, mag_a_d;
  logic                neg_q, neg_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0]   res_q, res_d;

  logic                a_neg, b_neg;
  logic [XLEN-1:0]     mag_a_in, mag_b_in;
  logic                accept, early, last_iter;
  logic [AccW-1:0]     partial, acc_sum;
  logic [2*XLEN+RADIX_BITS-1:0] shifted_full;

  assign a_neg    = mul.id_a_signed_r & mul.id_ra_value_r[XLEN-1];
  assign b_neg    = mul.id_b_signed_r & mul.id_rb_value_r[XLEN-1];
  // Unsigned magnitude: the most negative value maps to 2^(XLEN-1) without overflow.
  assign mag_a_in = a_neg ? -mul.id_ra_value_r : mul.id_ra_value_r;
  assign mag_b_in = b_neg ? -mul.id_rb_value_r : mul.id_rb_value_r;

  assign accept    = (state_q == StIdle) & mul.start_i & ~mul.kill_i;
  assign early     = (EARLY_OUT != 0) &
                     ((mul.id_ra_value_r == '0) | (mul.id_rb_value_r == '0));
  assign last_iter = (cnt_q == CntW'(N - 1));

  // Upper accumulator is widened by RADIX_BITS so the partial-product add never drops a carry.
  assign partial      = {{RADIX_BITS{1'b0}}, mag_a_q} * AccW'(prod_q[RADIX_BITS-1:0]);
  assign acc_sum      = {{RADIX_BITS{1'b0}}, prod_q[2*XLEN-1:XLEN]} + partial;
  assign shifted_full = {acc_sum, prod_q[XLEN-1:0]};

  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
    mag_a_d = mag_a_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          mag_a_d = mag_a_in;
          neg_d   = a_neg ^ b_neg;
          cnt_d   = '0;
          if (early) begin
            prod_d  = '0;
            state_d = StDone;
          end else begin
            prod_d  = {{XLEN{1'b0}}, mag_b_in};
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        prod_d = shifted_full[2*XLEN+RADIX_BITS-1:RADIX_BITS];
        cnt_d  = cnt_q + CntW'(1);
        if (last_iter) state_d = StFix;
      end
      StFix: begin
        if (neg_q) prod_d = -prod_q;
        state_d = StDone;
      end
      StDone: begin
        res_d   = prod_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A flush abandons the operation and must never disturb the published result.
    if (mul.kill_i) begin
      state_d = StIdle;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      prod_q  <= '0;
      mag_a_q <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      mag_a_q <= mag_a_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign mul.mul_res_r      = res_q;
  assign mul.mul_valid_o    = (state_q == StDone) & ~mul.kill_i;
  assign mul.busy_o         = (state_q != StIdle);
  assign mul.ex_stall_mul_w = ~mul.kill_i & (((state_q == StIdle) & mul.start_i) |
                                             (state_q == StCalc) | (state_q == StFix));
endmodule

// File: tb/tb_riscv_seq_multiplier_param.sv
// Randomized and directed checks of the iterative multiplier against an arithmetic model,
// across several radix / early-out configurations.
module tb_riscv_seq_multiplier_param;
  localparam int unsigned XLEN = 32;
  localparam int NI = 5;

  function automatic int unsigned rb_of(input int k);
    case (k)
      0, 1:    return 2;
      2:       return 1;
      3:       return 4;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned eo_of(input int k);
    return (k == 1) ? 0 : 1;
  endfunction

  logic clk = 1'b0;
  logic rst;
  logic start, kill, a_s, b_s;
  logic [XLEN-1:0] ra, rb;
  int sel;

  logic [2*XLEN-1:0] res_v [NI];
  logic [NI-1:0] valid_v, busy_v, stall_v;

  int n_cmp = 0;
  int n_err = 0;
  logic [2*XLEN-1:0] exp_res = '0;
  bit chk_res_next = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    riscv_seq_multiplier_param_if #(.XLEN(XLEN)) mif ();
    assign mif.start_i       = start & (sel == k);
    assign mif.kill_i        = kill;
    assign mif.id_a_signed_r = a_s;
    assign mif.id_b_signed_r = b_s;
    assign mif.id_ra_value_r = ra;
    assign mif.id_rb_value_r = rb;
    assign res_v[k]   = mif.mul_res_r;
    assign valid_v[k] = mif.mul_valid_o;
    assign busy_v[k]  = mif.busy_o;
    assign stall_v[k] = mif.ex_stall_mul_w;

    riscv_seq_multiplier_param #(
      .XLEN      (XLEN),
      .RADIX_BITS(rb_of(k)),
      .EARLY_OUT (eo_of(k))
    ) u_dut (
      .clk_i(clk),
      .rst_i(rst),
      .mul  (mif.slave)
    );
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  // Reference: interpret each operand per its signedness, multiply, keep 2*XLEN bits.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic as, input logic bs);
    longint sa, sb;
    sa = as ? longint'($signed(a)) : longint'({32'b0, a});
    sb = bs ? longint'($signed(b)) : longint'({32'b0, b});
    return 64'(sa * sb);
  endfunction

  // Issue one multiply on instance k, hold start until the valid pulse, check latency and result.
  task automatic run_mul(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic as, input logic bs, input logic [63:0] exp,
                         input bit hold);
    int lat_exp, stall_cnt, lat;
    bit got;
    lat_exp   = (eo_of(k) != 0 && (a == 0 || b == 0)) ? 1 : int'(XLEN / rb_of(k)) + 2;
    stall_cnt = 0;
    lat       = 0;
    got       = 0;
    sel       = k;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      start = 1'b1;
      if (i == 0) begin
        ra = a; rb = b; a_s = as; b_s = bs;
      end else begin
        ra = $urandom; rb = $urandom; a_s = 1'($urandom); b_s = 1'($urandom);
      end
      #1;
      if (i == 0 && chk_res_next) begin
        check_eq("res_b2b", res_v[k], exp_res);
        chk_res_next = 0;
      end
      if (stall_v[k]) stall_cnt++;
      if (valid_v[k]) begin
        got = 1;
        lat = i;
      end
    end
    check_eq("done_seen", 64'(got), 64'd1);
    if (!got) begin
      start = 1'b0;
      return;
    end
    check_eq("latency", 64'(lat), 64'(lat_exp));
    check_eq("stall_cycles", 64'(stall_cnt), 64'(lat_exp));
    exp_res = exp;
    if (hold) begin
      chk_res_next = 1;
    end else begin
      @(negedge clk);
      start = 1'b0;
      #1;
      check_eq("result", res_v[k], exp);
      check_eq("idle_after", 64'(busy_v[k]), 64'd0);
    end
  endtask

  initial begin
    int vcnt;
    logic [31:0] a, b;
    logic as, bs;
    rst = 1'b1; start = 1'b0; kill = 1'b0; sel = 0;
    ra = '0; rb = '0; a_s = 1'b0; b_s = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      check_eq("rst_res", res_v[k], 64'd0);
      check_eq("rst_valid", 64'(valid_v[k]), 64'd0);
      check_eq("rst_busy", 64'(busy_v[k]), 64'd0);
      check_eq("rst_stall", 64'(stall_v[k]), 64'd0);
    end

    // Directed cases on the default configuration.
    run_mul(0, 32'd8, 32'd8, 1'b0, 1'b0, 64'h40, 1'b1);
    run_mul(0, 32'd7, 32'd9, 1'b0, 1'b0, 64'h3F, 1'b0);
    run_mul(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 64'h1, 1'b0);
    run_mul(0, 32'h80000000, 32'h80000000, 1'b1, 1'b1, 64'h4000000000000000, 1'b0);
    run_mul(0, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1, 1'b0, 64'hFFFFFFF800000008, 1'b0);
    run_mul(0, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFF700000008, 1'b0);

    // Kill at CALC iteration 5: no valid, previous result kept.
    sel = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'b1;
      kill  = (i == 5);
      if (i == 0) begin
        ra = 32'd3; rb = 32'd5; a_s = 1'b0; b_s = 1'b0;
      end
      #1;
    end
    check_eq("kill_stall", 64'(stall_v[0]), 64'd0);
    check_eq("kill_valid", 64'(valid_v[0]), 64'd0);
    @(negedge clk);
    kill = 1'b0; start = 1'b0;
    #1;
    check_eq("kill_idle", 64'(busy_v[0]), 64'd0);
    vcnt = 0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (valid_v[0]) vcnt++;
    end
    check_eq("kill_no_valid", 64'(vcnt), 64'd0);
    check_eq("kill_res_kept", res_v[0], exp_res);

    // Kill in IDLE blocks acceptance.
    @(negedge clk);
    start = 1'b1; kill = 1'b1;
    #1;
    check_eq("kill_idle_stall", 64'(stall_v[0]), 64'd0);
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    #1;
    check_eq("kill_idle_busy", 64'(busy_v[0]), 64'd0);

    // Early-out vs fixed latency on a zero operand.
    run_mul(0, 32'd0, 32'h12345678, 1'b0, 1'b0, 64'd0, 1'b0);
    run_mul(1, 32'd0, 32'h12345678, 1'b0, 1'b0, 64'd0, 1'b0);

    // Random sweep over all configurations.
    for (int k = 0; k < NI; k++) begin
      for (int t = 0; t < 6; t++) begin
        a  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
        b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
        as = 1'($urandom);
        bs = 1'($urandom);
        run_mul(k, a, b, as, bs, ref_mul(a, b, as, bs),
                (t != 5) && ($urandom_range(0, 1) == 1));
      end
    end

    // Reset mid-CALC clears everything.
    sel = 0;
    repeat (4) begin
      @(negedge clk);
      start = 1'b1; ra = 32'd11; rb = 32'd13;
    end
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_mid_res", res_v[0], 64'd0);
    check_eq("rst_mid_busy", 64'(busy_v[0]), 64'd0);
    check_eq("rst_mid_valid", 64'(valid_v[0]), 64'd0);
    check_eq("rst_mid_stall", 64'(stall_v[0]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
